// File: rtl/shift_reg_ctrl.sv
// Sequencing controller for an N-bit universal shift register: one parallel load, then N paced shifts.
// Build option: define SHIFT_REG_CTRL_ROTATE_EN to feed q back into shiftIn so the loaded word rotates.
module shift_reg_ctrl #(
    parameter int N   = 4,
    parameter int DIV = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] data_in,
    input  logic         dir,
    input  logic         fill,
    input  logic         abort,
    input  logic [N-1:0] q,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [1:0]   s,
    output logic [N-1:0] a,
    output logic         shiftIn
);

    localparam int BIT_W = $clog2(N + 1);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(N - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [BIT_W-1:0] BIT_ZERO = {BIT_W{1'b0}};
    localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};

    localparam logic [1:0] CMD_HOLD  = 2'b00;
    localparam logic [1:0] CMD_LEFT  = 2'b01;
    localparam logic [1:0] CMD_RIGHT = 2'b10;
    localparam logic [1:0] CMD_LOAD  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        SHIFT = 2'b10,
        DONE  = 2'b11
    } stateT;

    function automatic logic parityOf(input logic [N-1:0] v);
        return ^v;
    endfunction

    stateT            stateR;
    stateT            stateNextS;
    logic [N-1:0]     data_r;
    logic [N-1:0]     dataNextS;
    logic             dir_r;
    logic             dirNextS;
    logic [BIT_W-1:0] bit_cnt;
    logic [BIT_W-1:0] bitCntNextS;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] divCntNextS;

    logic [1:0]       sNextS;
    logic             readyNextS;
    logic             busyNextS;
    logic             doneNextS;
    logic             unusedInS;

`ifndef SHIFT_REG_CTRL_ROTATE_EN
    logic             fill_r;
    logic             fillNextS;
    logic             shiftInR;
    logic             shiftInNextS;
`endif

    // Next-state and next-register computation; abort overrides every state.
    always_comb begin
        stateNextS  = stateR;
        dataNextS   = data_r;
        dirNextS    = dir_r;
        bitCntNextS = bit_cnt;
        divCntNextS = div_cnt;
`ifndef SHIFT_REG_CTRL_ROTATE_EN
        fillNextS   = fill_r;
`endif
        if (abort) begin
            stateNextS  = IDLE;
            bitCntNextS = BIT_ZERO;
            divCntNextS = DIV_ZERO;
        end else begin
            case (stateR)
                IDLE: begin
                    if (start) begin
                        stateNextS = LOAD;
                        dataNextS  = data_in;
                        dirNextS   = dir;
`ifndef SHIFT_REG_CTRL_ROTATE_EN
                        fillNextS  = fill;
`endif
                    end else begin
                        stateNextS = IDLE;
                    end
                end
                LOAD: begin
                    stateNextS  = SHIFT;
                    bitCntNextS = BIT_ZERO;
                    divCntNextS = DIV_LAST;
                end
                SHIFT: begin
                    // A zero pacing count marks a command cycle.
                    if (div_cnt == DIV_ZERO) begin
                        divCntNextS = DIV_LAST;
                        bitCntNextS = bit_cnt + BIT_W'(1);
                        if (bit_cnt == LAST_BIT) begin
                            stateNextS = DONE;
                        end else begin
                            stateNextS = SHIFT;
                        end
                    end else begin
                        divCntNextS = div_cnt - DIV_W'(1);
                    end
                end
                DONE: begin
                    stateNextS  = IDLE;
                    bitCntNextS = BIT_ZERO;
                    divCntNextS = DIV_ZERO;
                end
                default: begin
                    stateNextS  = IDLE;
                    bitCntNextS = BIT_ZERO;
                    divCntNextS = DIV_ZERO;
                end
            endcase
        end
    end

    // Output decode from the next register values so outputs can be flopped alongside the state.
    always_comb begin
        sNextS     = CMD_HOLD;
        readyNextS = 1'b0;
        busyNextS  = 1'b0;
        doneNextS  = 1'b0;
`ifndef SHIFT_REG_CTRL_ROTATE_EN
        shiftInNextS = 1'b0;
`endif
        case (stateNextS)
            IDLE: begin
                readyNextS = 1'b1;
            end
            LOAD: begin
                busyNextS = 1'b1;
                sNextS    = CMD_LOAD;
            end
            SHIFT: begin
                busyNextS = 1'b1;
`ifndef SHIFT_REG_CTRL_ROTATE_EN
                shiftInNextS = fillNextS;
`endif
                if (divCntNextS == DIV_ZERO) begin
                    sNextS = dirNextS ? CMD_RIGHT : CMD_LEFT;
                end else begin
                    sNextS = CMD_HOLD;
                end
            end
            DONE: begin
                busyNextS = 1'b1;
                doneNextS = 1'b1;
            end
            default: begin
                readyNextS = 1'b1;
            end
        endcase
    end

    // State, captured request and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateR  <= IDLE;
            data_r  <= {N{1'b0}};
            dir_r   <= 1'b0;
            bit_cnt <= BIT_ZERO;
            div_cnt <= DIV_ZERO;
            s       <= CMD_HOLD;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifndef SHIFT_REG_CTRL_ROTATE_EN
            fill_r   <= 1'b0;
            shiftInR <= 1'b0;
`endif
        end else begin
            stateR  <= stateNextS;
            data_r  <= dataNextS;
            dir_r   <= dirNextS;
            bit_cnt <= bitCntNextS;
            div_cnt <= divCntNextS;
            s       <= sNextS;
            ready   <= readyNextS;
            busy    <= busyNextS;
            done    <= doneNextS;
`ifndef SHIFT_REG_CTRL_ROTATE_EN
            fill_r   <= fillNextS;
            shiftInR <= shiftInNextS;
`endif
        end
    end

    assign a = data_r;

`ifdef SHIFT_REG_CTRL_ROTATE_EN
    // The bit leaving the register is fed back in; it must track q live between commands.
    assign shiftIn   = (stateR == SHIFT) ? (dir_r ? q[0] : q[N-1]) : 1'b0;
    assign unusedInS = fill;
`else
    assign shiftIn   = shiftInR;
    assign unusedInS = parityOf(q);
`endif

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Directed bench for shift_reg_ctrl: two instances (DIV=1 and DIV=3) each driving a behavioural shift register.
module tb_shift_reg_ctrl;

`ifdef SHIFT_REG_CTRL_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    // Final register contents per scenario, for fill and rotate builds.
    localparam logic [3:0] T1_Q = ROT ? 4'b0110 : 4'b1111;
    localparam logic [3:0] T2_Q = ROT ? 4'b1001 : 4'b0000;
    localparam logic [3:0] T4_Q = ROT ? 4'b1001 : 4'b1011;
    localparam logic [3:0] T5_Q = ROT ? 4'b1010 : 4'b0000;

    logic       clk = 1'b0;
    logic       rst;

    logic       start1, dir1, fill1, abort1;
    logic [3:0] data1;
    logic [3:0] q1 = 4'b0000;
    logic       ready1, busy1, done1, shiftIn1;
    logic [1:0] s1;
    logic [3:0] a1;

    logic       start3, dir3, fill3, abort3;
    logic [3:0] data3;
    logic [3:0] q3 = 4'b0000;
    logic       ready3, busy3, done3, shiftIn3;
    logic [1:0] s3;
    logic [3:0] a3;

    int testsRun    = 0;
    int testsFailed = 0;

    shift_reg_ctrl #(.N(4), .DIV(1)) u1 (
        .clk(clk), .reset(rst), .start(start1), .data_in(data1), .dir(dir1),
        .fill(fill1), .abort(abort1), .q(q1), .ready(ready1), .busy(busy1),
        .done(done1), .s(s1), .a(a1), .shiftIn(shiftIn1)
    );

    shift_reg_ctrl #(.N(4), .DIV(3)) u3 (
        .clk(clk), .reset(rst), .start(start3), .data_in(data3), .dir(dir3),
        .fill(fill3), .abort(abort3), .q(q3), .ready(ready3), .busy(busy3),
        .done(done3), .s(s3), .a(a3), .shiftIn(shiftIn3)
    );

    always #5 clk = ~clk;

    // Behavioural universal shift registers fed by the controllers.
    always @(posedge clk) begin
        case (s1)
            2'b01:   q1 <= {q1[2:0], shiftIn1};
            2'b10:   q1 <= {shiftIn1, q1[3:1]};
            2'b11:   q1 <= a1;
            default: q1 <= q1;
        endcase
        case (s3)
            2'b01:   q3 <= {q3[2:0], shiftIn3};
            2'b10:   q3 <= {shiftIn3, q3[3:1]};
            2'b11:   q3 <= a3;
            default: q3 <= q3;
        endcase
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int mask, wrongDir, extraLoad, doneAt, readyAt, doneCnt;
        int loads, dones, readies, dblReady, badBusy;
        logic prevReady;

        rst = 1'b1;
        start1 = 1'b0; dir1 = 1'b0; fill1 = 1'b0; abort1 = 1'b0; data1 = 4'b0000;
        start3 = 1'b0; dir3 = 1'b0; fill3 = 1'b0; abort3 = 1'b0; data3 = 4'b0000;
        #2;
        checkVal("rst_ready", 32'(ready1), 32'd1);
        checkVal("rst_busy", 32'(busy1), 32'd0);
        checkVal("rst_done", 32'(done1), 32'd0);
        checkVal("rst_s", 32'(s1), 32'd0);
        checkVal("rst_a", 32'(a1), 32'd0);
        checkVal("rst_shiftIn", 32'(shiftIn1), 32'd0);
        checkVal("rst_ready3", 32'(ready3), 32'd1);
        #1 rst = 1'b0;

        // Scenario 1: DIV=1 left shift, fill=1.
        data1 = 4'b0110; dir1 = 1'b0; fill1 = 1'b1; start1 = 1'b1;
        tick();
        checkVal("t1_load_s", 32'(s1), 32'd3);
        checkVal("t1_a", 32'(a1), 32'h6);
        checkVal("t1_busy", 32'(busy1), 32'd1);
        checkVal("t1_ready", 32'(ready1), 32'd0);
        start1 = 1'b0; data1 = 4'b1001; dir1 = 1'b1; fill1 = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checkVal($sformatf("t1_shift_s%0d", i), 32'(s1), 32'd1);
            checkVal($sformatf("t1_shiftIn%0d", i), 32'(shiftIn1), 32'(ROT ? q1[3] : 1'b1));
            checkVal($sformatf("t1_nodone%0d", i), 32'(done1), 32'd0);
        end
        tick();
        checkVal("t1_done", 32'(done1), 32'd1);
        checkVal("t1_done_s", 32'(s1), 32'd0);
        checkVal("t1_done_busy", 32'(busy1), 32'd1);
        checkVal("t1_q", 32'(q1), 32'(T1_Q));
        tick();
        checkVal("t1_ready_back", 32'(ready1), 32'd1);
        checkVal("t1_done_off", 32'(done1), 32'd0);
        checkVal("t1_busy_off", 32'(busy1), 32'd0);

        // Scenario 2: DIV=3 right shift while fill and data wiggle after accept.
        data3 = 4'b1001; dir3 = 1'b1; fill3 = 1'b0; start3 = 1'b1;
        tick();
        checkVal("t2_load_s", 32'(s3), 32'd3);
        start3 = 1'b0; data3 = 4'b0110; dir3 = 1'b0;
        mask = 0; wrongDir = 0; extraLoad = 0; doneAt = 0; readyAt = 0; doneCnt = 0;
        for (int j = 1; j <= 20; j++) begin
            fill3 = ~fill3;
            tick();
            if (s3 == 2'b10) mask = mask | (1 << j);
            if (s3 == 2'b01) wrongDir++;
            if (s3 == 2'b11) extraLoad++;
            if (done3) doneCnt++;
            if (done3 && doneAt == 0) doneAt = j;
            if (ready3 && readyAt == 0) readyAt = j;
            if (readyAt != 0) break;
        end
        checkVal("t2_cmd_cycles", 32'(mask), 32'h1248);
        checkVal("t2_wrong_dir", 32'(wrongDir), 32'd0);
        checkVal("t2_extra_load", 32'(extraLoad), 32'd0);
        checkVal("t2_done_at", 32'(doneAt), 32'd13);
        checkVal("t2_done_cnt", 32'(doneCnt), 32'd1);
        checkVal("t2_ready_at", 32'(readyAt), 32'd14);
        checkVal("t2_q", 32'(q3), 32'(T2_Q));

        // Scenario 3: start held through three back-to-back operations.
        data1 = 4'b0011; dir1 = 1'b0; fill1 = 1'b0; start1 = 1'b1;
        loads = 0; dones = 0; readies = 0; dblReady = 0; badBusy = 0; prevReady = 1'b0;
        for (int j = 0; j <= 20; j++) begin
            tick();
            if (s1 == 2'b11) loads++;
            if (done1) dones++;
            if (ready1) readies++;
            if (ready1 && prevReady) dblReady++;
            if (busy1 == ready1) badBusy++;
            prevReady = ready1;
        end
        start1 = 1'b0;
        checkVal("t3_loads", 32'(loads), 32'd3);
        checkVal("t3_dones", 32'(dones), 32'd3);
        checkVal("t3_idle_visits", 32'(readies), 32'd3);
        checkVal("t3_long_idle", 32'(dblReady), 32'd0);
        checkVal("t3_busy_ready", 32'(badBusy), 32'd0);
        tick();
        checkVal("t3_idle_after", 32'(ready1), 32'd1);

        // Scenario 4: abort on the second shift command, then abort with start in IDLE.
        data1 = 4'b0110; dir1 = 1'b0; fill1 = 1'b1; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        tick();
        checkVal("t4_second_cmd", 32'(s1), 32'd1);
        abort1 = 1'b1;
        tick();
        checkVal("t4_abort_s", 32'(s1), 32'd0);
        checkVal("t4_abort_ready", 32'(ready1), 32'd1);
        checkVal("t4_abort_busy", 32'(busy1), 32'd0);
        checkVal("t4_abort_done", 32'(done1), 32'd0);
        checkVal("t4_abort_q", 32'(q1), 32'(T4_Q));
        abort1 = 1'b0;
        tick();
        checkVal("t4_no_late_done", 32'(done1), 32'd0);
        checkVal("t4_q_held", 32'(q1), 32'(T4_Q));
        abort1 = 1'b1; start1 = 1'b1;
        tick();
        checkVal("t4_abstart_ready", 32'(ready1), 32'd1);
        checkVal("t4_abstart_s", 32'(s1), 32'd0);
        checkVal("t4_abstart_busy", 32'(busy1), 32'd0);
        abort1 = 1'b0; start1 = 1'b0;
        tick();
        checkVal("t4_no_deferred", 32'(s1), 32'd0);
        checkVal("t4_still_idle", 32'(ready1), 32'd1);

        // Scenario 5: asynchronous reset mid-SHIFT, then a clean operation.
        data1 = 4'b0110; dir1 = 1'b0; fill1 = 1'b1; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        tick();
        checkVal("t5_in_shift", 32'(busy1), 32'd1);
        #3 rst = 1'b1;
        #1;
        checkVal("t5_rst_s", 32'(s1), 32'd0);
        checkVal("t5_rst_shiftIn", 32'(shiftIn1), 32'd0);
        checkVal("t5_rst_ready", 32'(ready1), 32'd1);
        checkVal("t5_rst_busy", 32'(busy1), 32'd0);
        #2 rst = 1'b0;
        data1 = 4'b1010; dir1 = 1'b1; fill1 = 1'b0; start1 = 1'b1;
        tick();
        checkVal("t5_reload_s", 32'(s1), 32'd3);
        start1 = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checkVal($sformatf("t5_shift_s%0d", i), 32'(s1), 32'd2);
        end
        tick();
        checkVal("t5_done", 32'(done1), 32'd1);
        checkVal("t5_q", 32'(q1), 32'(T5_Q));
        tick();
        checkVal("t5_ready_back", 32'(ready1), 32'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
